// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the SIPO frame receive controller.
//   state_t   : receive FSM state encoding (IDLE / SHIFT / STOP)
//   START_BIT : line level that opens a frame
//   STOP_BIT  : line level expected in the stop-bit slot
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-first serial-in / parallel-out shift register.
//   clk      : system clock
//   rst      : asynchronous active-high clear
//   shift_en : shift sin into the LSB when high
//   sin      : serial data input
//   pout     : parallel contents, first received bit in the MSB
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (shift_en) sreg_d = {sreg_q[WIDTH-2:0], sin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sreg_q <= '0;
    else     sreg_q <= sreg_d;
  end

  assign pout = sreg_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Receive controller for framed serial words: start bit (0), WIDTH data
// bits MSB first, stop bit (1). Bits are sampled only on sin_en strobes.
// Completed words are presented on a valid/ready port backed by a single
// holding register.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   sin       : serial data input
//   sin_en    : bit strobe, sin sampled only when high
//   out_ready : consumer accepts out_data on out_valid && out_ready
//   clr_ovr   : synchronous clear of the sticky overrun flag
//   out_data  : held captured word
//   out_valid : out_data holds an unconsumed word
//   busy      : receiver is inside a frame (registered)
//   frame_err : one-cycle pulse when the stop bit was sampled as 0
//   overrun   : sticky, a completed word was dropped (holding reg full)
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             shift_en;
  logic             complete;
  logic [WIDTH-1:0] sreg;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .sin      (sin),
    .pout     (sreg)
  );

  // Next-state logic; every transition is gated by the bit strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    complete = 1'b0;
    ferr_d   = 1'b0;
    if (sin_en) begin
      case (state_q)
        ST_IDLE: begin
          if (sin == START_BIT) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = ST_STOP;
            cnt_d   = '0;
          end
        end
        ST_STOP: begin
          // A low stop bit returns to IDLE; it never doubles as a start bit.
          state_d = ST_IDLE;
          if (sin == STOP_BIT) complete = 1'b1;
          else                 ferr_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Holding register and flags.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = sreg;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b1;
  logic       sin_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [3:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;

  sipo_frame_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached got=timeout want=finish");
    $fatal(1);
  end

  // One bit slot: 9 quiet cycles then a 1-cycle strobe; returns 1ns after
  // the sampling edge.
  task automatic strobe(input logic b);
    repeat (9) @(posedge clk);
    #1 sin = b; sin_en = 1'b1;
    @(posedge clk);
    #1 sin_en = 1'b0; sin = 1'b1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop);
    strobe(1'b0);
    for (int unsigned i = 0; i < 4; i++) strobe(d[3-i]);
    strobe(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_data !== 4'b0000) begin bad++; $display("FAIL reset_data got=%b want=0000", out_data); end
    total++; if ({out_valid, busy, frame_err, overrun} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {out_valid, busy, frame_err, overrun}); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL reset_release got=%b want=00", {out_valid, busy}); end
  endtask

  task automatic test_basic_frame;
    out_ready = 1'b1;
    strobe(1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pre_valid got=%b want=0", out_valid); end
    strobe(1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 4'b1011) begin bad++; $display("FAIL basic_data got=%b want=1011", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b want=0", out_valid); end
  endtask

  task automatic test_frame_error;
    send_frame(4'b1100, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b want=1", frame_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_one_cycle got=%b want=0", frame_err); end
    // IDLE must have been reached: a fresh good frame captures cleanly.
    send_frame(4'b0101, 1'b1);
    total++; if (out_data !== 4'b0101 || out_valid !== 1'b1) begin bad++; $display("FAIL ferr_recover got=%b/%b want=0101/1", out_data, out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    send_frame(4'b1011, 1'b1);
    total++; if (out_data !== 4'b1011 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_first got=%b/%b want=1011/1", out_data, out_valid); end
    send_frame(4'b0110, 1'b1);
    total++; if (out_data !== 4'b1011) begin bad++; $display("FAIL ovr_keep got=%b want=1011", out_data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
    repeat (3) @(posedge clk); #1;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    clr_ovr = 1'b1;
    @(posedge clk); #1 clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
    total++; if (out_valid !== 1'b1 || out_data !== 4'b1011) begin bad++; $display("FAIL ovr_hold got=%b/%b want=1011/1", out_data, out_valid); end
  endtask

  task automatic test_back_to_back;
    strobe(1'b0);
    strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b0);
    repeat (9) @(posedge clk);
    #1 sin = 1'b1; sin_en = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 sin_en = 1'b0; out_ready = 1'b0;
    total++; if (out_data !== 4'b0110) begin bad++; $display("FAIL b2b_data got=%b want=0110", out_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b want=0", overrun); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || out_data !== 4'b0110) begin bad++; $display("FAIL b2b_consume got=%b/%b want=0110/0", out_data, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    strobe(1'b0); strobe(1'b1); strobe(1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mrst_busy_pre got=%b want=1", busy); end
    #2 rst = 1'b1;
    #1;
    total++; if ({busy, out_valid, out_data} !== 6'b000000) begin bad++; $display("FAIL mrst_async got=%b want=000000", {busy, out_valid, out_data}); end
    #2 rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    total++; if ({busy, out_valid, frame_err} !== 3'b000) begin bad++; $display("FAIL mrst_release got=%b want=000", {busy, out_valid, frame_err}); end
    send_frame(4'b1100, 1'b1);
    total++; if (out_data !== 4'b1100 || out_valid !== 1'b1) begin bad++; $display("FAIL mrst_frame got=%b/%b want=1100/1", out_data, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_consume got=%b want=0", out_valid); end
  endtask

  task automatic test_idle_line;
    for (int i = 0; i < 50; i++) begin
      strobe(1'b1);
      total++;
      if ({busy, out_valid, frame_err, overrun, out_data} !== 8'b0000_1100) begin
        bad++;
        $display("FAIL idle_%0d got=%b want=00001100", i, {busy, out_valid, frame_err, overrun, out_data});
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_frame_error;
    test_overrun;
    test_back_to_back;
    test_mid_reset;
    test_idle_line;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
